// File: rtl/fp_pkg.sv
// Shared float-format definitions for the integer encoder and the float adder.
// Word layout is {sign, exp[5:0], frac[24:0]} with a hidden leading one.
package fp_pkg;

    localparam int FP_W   = 32;
    localparam int EXP_W  = 6;
    localparam int FRAC_W = 25;

    localparam logic [EXP_W-1:0] EXP_MAX = 6'd63;

    localparam logic [3:0] ST_EXACT   = 4'd0;
    localparam logic [3:0] ST_OVF     = 4'd1;
    localparam logic [3:0] ST_UNF     = 4'd2;
    localparam logic [3:0] ST_INEXACT = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_NORMALIZE = 2'd1,
        S_PACK      = 2'd2,
        S_HOLD      = 2'd3
    } enc_state_t;

    // Magnitude of a two's-complement word; -2^31 maps to 0x8000_0000.
    function automatic logic [31:0] abs_mag(input logic [31:0] v);
        logic [31:0] r;
        if (v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/int_to_fp_encoder.sv
// Converts a signed 32-bit integer into the float word, normalising one bit
// per clock; result is held until the consumer takes it.
module int_to_fp_encoder
    import fp_pkg::*;
#(
    parameter int BIAS = 31
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:31] int_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] data_out,
    output logic [0:3]  status_out
);

    enc_state_t  r_state;
    enc_state_t  w_next;
    logic        r_sign;
    logic [0:31] r_mag;
    logic [4:0]  r_pos;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [0:31] r_data;
    logic [0:3]  r_status;

    logic        w_accept;
    logic        w_handshake;
    logic        w_norm_done;
    logic [6:0]  w_exp;
    logic [0:31] w_pack_data;
    logic [0:3]  w_pack_status;

    assign w_accept    = in_valid & r_in_ready;
    assign w_handshake = r_out_valid & out_ready;
    assign w_norm_done = (r_mag == 32'd0) | r_mag[0];
    assign w_exp       = {2'b00, r_pos} + BIAS[6:0];

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign data_out   = r_data;
    assign status_out = r_status;

    // Next-state logic for the IDLE/NORMALIZE/PACK/HOLD sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_NORMALIZE;
                else          w_next = S_IDLE;
            end
            S_NORMALIZE: begin
                if (w_norm_done) w_next = S_PACK;
                else             w_next = S_NORMALIZE;
            end
            S_PACK:  w_next = S_HOLD;
            S_HOLD: begin
                if (w_handshake) w_next = S_IDLE;
                else             w_next = S_HOLD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pack the normalised magnitude; exponent compared at 7 bits to catch overflow.
    always_comb begin
        w_pack_data   = 32'd0;
        w_pack_status = ST_EXACT;
        if (r_mag == 32'd0) begin
            w_pack_data   = 32'd0;
            w_pack_status = ST_EXACT;
        end else if (w_exp >= 7'd63) begin
            w_pack_data   = {r_sign, EXP_MAX, 25'd0};
            w_pack_status = ST_OVF;
        end else begin
            w_pack_data   = {r_sign, w_exp[5:0], r_mag[1:25]};
            w_pack_status = (|r_mag[26:31]) ? ST_INEXACT : ST_EXACT;
        end
    end

    // State register.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            r_sign      <= 1'b0;
            r_mag       <= 32'd0;
            r_pos       <= 5'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_data      <= 32'd0;
            r_status    <= 4'd0;
        end else begin
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_HOLD);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= int_in[0];
                        r_mag  <= abs_mag(int_in);
                        r_pos  <= 5'd31;
                    end else begin
                        r_sign <= r_sign;
                    end
                end
                S_NORMALIZE: begin
                    if (!w_norm_done) begin
                        r_mag <= {r_mag[1:31], 1'b0};
                        r_pos <= r_pos - 5'd1;
                    end else begin
                        r_mag <= r_mag;
                    end
                end
                S_PACK: begin
                    r_data   <= w_pack_data;
                    r_status <= w_pack_status;
                end
                default: begin
                    r_data <= r_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp_encoder.sv
// Directed bench for int_to_fp_encoder: default-bias instance plus a BIAS=40
// instance for the exponent-overflow path.
module tb_int_to_fp_encoder;

    logic        clk;
    logic        reset;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_int_in, a_data_out;
    logic [3:0]  a_status_out;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_int_in, b_data_out;
    logic [3:0]  b_status_out;

    int errors = 0;
    int checks = 0;

    int_to_fp_encoder u_dut_a (
        .clock_100kHz (clk),
        .reset        (reset),
        .in_valid     (a_in_valid),
        .in_ready     (a_in_ready),
        .int_in       (a_int_in),
        .out_valid    (a_out_valid),
        .out_ready    (a_out_ready),
        .data_out     (a_data_out),
        .status_out   (a_status_out)
    );

    int_to_fp_encoder #(.BIAS(40)) u_dut_b (
        .clock_100kHz (clk),
        .reset        (reset),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .int_in       (b_int_in),
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .data_out     (b_data_out),
        .status_out   (b_status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one value on instance A, measure latency, check result and handshake.
    task automatic convert_a(input string tag, input logic [31:0] val, input int exp_lat,
                             input logic [31:0] exp_data, input logic [3:0] exp_st);
        int n;
        chk({tag, "_ready_before"}, {31'd0, a_in_ready}, 32'd1);
        a_int_in   = val;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, a_in_ready}, 32'd0);
        n = 0;
        while (a_out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_data"}, a_data_out, exp_data);
        chk({tag, "_status"}, {28'd0, a_status_out}, {28'd0, exp_st});
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, a_out_valid}, 32'd0);
        chk({tag, "_data_kept"}, a_data_out, exp_data);
        chk({tag, "_ready_after"}, {31'd0, a_in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        reset       = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_int_in    = 32'd0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_int_in    = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_data", a_data_out, 32'd0);
        chk("rst_status", {28'd0, a_status_out}, 32'd0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", {31'd0, a_in_ready}, 32'd1);

        // Directed conversions (expected values derived by hand)
        convert_a("one",     32'h0000_0001, 33, 32'h3E00_0000, 4'd0);
        convert_a("neg6",    32'hFFFF_FFFA, 31, 32'hC300_0000, 4'd0);
        convert_a("maxpos",  32'h7FFF_FFFF,  3, 32'h7BFF_FFFF, 4'd3);
        convert_a("zero",    32'h0000_0000,  2, 32'h0000_0000, 4'd0);
        convert_a("minneg",  32'h8000_0000,  2, 32'hFC00_0000, 4'd0);
        convert_a("ff",      32'h0000_00FF, 26, 32'h4DFC_0000, 4'd0);

        // Overflow with BIAS=40, then a long stall with ignored input pulses
        chk("ovf_ready_before", {31'd0, b_in_ready}, 32'd1);
        b_int_in   = 32'h4000_0000;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n = 0;
        while (b_out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ovf_latency", n, 3);
        chk("ovf_data", b_data_out, 32'h7E00_0000);
        chk("ovf_status", {28'd0, b_status_out}, 32'd1);
        b_int_in = 32'h0000_0001;
        for (int i = 0; i < 10; i++) begin
            b_in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, b_out_valid}, 32'd1);
            chk("stall_data", b_data_out, 32'h7E00_0000);
            chk("stall_ready", {31'd0, b_in_ready}, 32'd0);
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("stall_release_valid", {31'd0, b_out_valid}, 32'd0);
        chk("stall_release_ready", {31'd0, b_in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("stall_no_spurious", {31'd0, b_out_valid}, 32'd0);

        // Reset during NORMALIZE discards the conversion
        a_int_in   = 32'h0000_0001;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("midrst_data", a_data_out, 32'd0);
        chk("midrst_status", {28'd0, a_status_out}, 32'd0);
        chk("midrst_in_ready", {31'd0, a_in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("postrst_ready", {31'd0, a_in_ready}, 32'd1);
        chk("postrst_no_valid", {31'd0, a_out_valid}, 32'd0);
        convert_a("two", 32'h0000_0002, 32, 32'h4000_0000, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
